// File: rtl/clk_en_gen.sv
// Runtime-programmable clock-enable generator: NUM_CH channels of divided strobes and
// square waves from one fabric clock, realigned in phase after every settle period.
module clk_en_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 256,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_en,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

  localparam int LCW = $clog2(LOCK_CYCLES);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

  typedef enum logic {SETTLE, RUN} state_t;

  state_t            state;
  logic [LCW-1:0]    lock_cnt;
  logic [NUM_CH-1:0] en;
  logic [DIV_W-1:0]  div   [NUM_CH];
  logic [DIV_W-1:0]  phase [NUM_CH];
  logic [DIV_W-1:0]  cnt   [NUM_CH];
  logic              accept;

  // A phase beyond the period wraps onto the last count, i.e. strobe on the first RUN cycle.
  function automatic logic [DIV_W-1:0] clamp_phase(input logic [DIV_W-1:0] p,
                                                   input logic [DIV_W-1:0] d);
    return (p > d) ? d : p;
  endfunction

  assign accept = cfg_we && (int'(cfg_ch) < NUM_CH);

  always_comb begin
    ce_out = '0;
    for (int i = 0; i < NUM_CH; i++)
      ce_out[i] = locked & en[i] & (cnt[i] == div[i]);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state    <= SETTLE;
      locked   <= 1'b0;
      lock_cnt <= '0;
      en       <= '0;
      clk_out  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div[i]   <= '0;
        phase[i] <= '0;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept && (cfg_ch == CH_W'(i))) begin
          en[i]    <= cfg_en;
          div[i]   <= cfg_div;
          phase[i] <= cfg_phase;
        end
      end

      if (state == RUN) begin
        for (int i = 0; i < NUM_CH; i++) begin
          cnt[i] <= (cnt[i] == div[i]) ? '0 : cnt[i] + DIV_W'(1);
          if (ce_out[i])
            clk_out[i] <= ~clk_out[i];
        end
      end

      // A write always wins over the settle-complete edge so every channel restarts together.
      if (accept) begin
        state    <= SETTLE;
        locked   <= 1'b0;
        lock_cnt <= '0;
      end else if (state == SETTLE) begin
        if (lock_cnt == LOCK_LAST) begin
          state    <= RUN;
          locked   <= 1'b1;
          lock_cnt <= '0;
          clk_out  <= '0;
          for (int i = 0; i < NUM_CH; i++)
            cnt[i] <= clamp_phase(phase[i], div[i]);
        end else begin
          lock_cnt <= lock_cnt + LCW'(1);
        end
      end
    end
  end

endmodule
